// File: rtl/dca_matrix_lsu_arbiter.sv
// dca_matrix_lsu_arbiter
//  Shares one matrix LSU port among three instruction channels of the matrix
//  MAC sequencer (ch0 = operand A read, ch1 = operand B read, ch2 = result
//  read/write). Grants round-robin per instruction, remembers the channel of
//  every read it issues in an order FIFO, and steers the in-order read data
//  back to that channel.
//
//  Handshake semantics (all channels): a transfer happens on a cycle where
//  valid and ready are both 1; once valid is raised toward the LSU the granted
//  instruction is held stable until the transfer.
//
//  Ports
//   clk, rstnn      clock, asynchronous active-low reset
//   clear           synchronous clear of all state
//   enable          0 freezes state and forces every valid/ready output low
//   req_*           per-channel instruction valid/ready/instruction
//   lsu_valid/ready/inst   granted instruction toward the LSU
//   lsu_rvalid/rready/rdata read-data beats from the LSU, in issue order
//   rsp_valid/ready/data   per-channel read data (data bus is shared)
//   outstanding     reads issued but not yet returned
//   busy            outstanding != 0 or an instruction is being offered
//   orphan_error    sticky flag: read data arrived with nothing outstanding

`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif
`ifndef BW_DCA_MATRIX_LSU_INST_OPCODE
`define BW_DCA_MATRIX_LSU_INST_OPCODE 2
`endif
`ifndef DCA_MATRIX_LSU_INST_OPCODE_READ
`define DCA_MATRIX_LSU_INST_OPCODE_READ 2'd1
`endif

module dca_matrix_lsu_arbiter #(
   parameter int NUM_REQ         = 3,
   parameter int BW_LSU_INST     = `BW_DCA_MATRIX_LSU_INST,
   parameter int BW_RDATA        = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                              clk,
   input  logic                              rstnn,
   input  logic                              clear,
   input  logic                              enable,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*BW_LSU_INST-1:0]    req_inst,
   output logic                              lsu_valid,
   input  logic                              lsu_ready,
   output logic [BW_LSU_INST-1:0]            lsu_inst,
   input  logic                              lsu_rvalid,
   output logic                              lsu_rready,
   input  logic [BW_RDATA-1:0]               lsu_rdata,
   output logic [NUM_REQ-1:0]                rsp_valid,
   input  logic [NUM_REQ-1:0]                rsp_ready,
   output logic [BW_RDATA-1:0]               rsp_data,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
   output logic                              busy,
   output logic                              orphan_error
);

   localparam int PW = $clog2(MAX_OUTSTANDING);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int OW = `BW_DCA_MATRIX_LSU_INST_OPCODE;

   logic               active;
   logic [NUM_REQ-1:0] is_read;
   logic [NUM_REQ-1:0] eligible;
   logic               full;
   logic               empty;
   logic               found;
   logic               use_lock;
   logic [IW-1:0]      search_idx;
   logic [IW-1:0]      win;
   logic [IW-1:0]      head;
   logic [IW-1:0]      cand;
   logic               hs;
   logic               push;
   logic               pop;

   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic               lock_vld_q, lock_vld_d;
   logic [IW-1:0]      lock_idx_q, lock_idx_d;
   logic [PW:0]        wr_ptr_q, wr_ptr_d;
   logic [PW:0]        rd_ptr_q, rd_ptr_d;
   logic               orphan_q, orphan_d;
   logic [IW-1:0]      fifo_q [MAX_OUTSTANDING];
   logic [IW-1:0]      fifo_d [MAX_OUTSTANDING];

   // Reset is folded in so every valid/ready output is low while rstnn = 0.
   assign active = enable & rstnn;

   // Extra MSB on the pointers distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                  (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign head  = fifo_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         is_read[i]  = (req_inst[i*BW_LSU_INST +: OW] == OW'(`DCA_MATRIX_LSU_INST_OPCODE_READ));
         // A read needs a free FIFO slot now; a pop in the same cycle gives no credit.
         eligible[i] = active & req_valid[i] & ~(is_read[i] & full);
      end
   end

   // Round-robin search starting at the pointer, wrapping over the channels.
   always_comb begin
      found      = 1'b0;
      search_idx = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && eligible[cand]) begin
            found      = 1'b1;
            search_idx = cand;
         end
      end
   end

   // A stalled offer keeps its winner; if that channel drops out, fall back to the search.
   assign use_lock  = lock_vld_q & eligible[lock_idx_q];
   assign win       = use_lock ? lock_idx_q : search_idx;
   assign lsu_valid = use_lock | found;
   assign lsu_inst  = req_inst[int'(win)*BW_LSU_INST +: BW_LSU_INST];

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = lsu_valid & lsu_ready & (win == IW'(i));
      end
   end

   assign hs   = lsu_valid & lsu_ready;
   assign push = hs & is_read[win];

   // Response routing; with nothing outstanding the beat is drained unrouted.
   always_comb begin
      rsp_valid = '0;
      if (active && lsu_rvalid && !empty) begin
         rsp_valid[head] = 1'b1;
      end
   end
   assign lsu_rready = active & (empty | rsp_ready[head]);
   assign pop        = active & lsu_rvalid & ~empty & rsp_ready[head];
   assign rsp_data   = lsu_rdata;

   assign outstanding  = wr_ptr_q - rd_ptr_q;
   assign busy         = (outstanding != '0) | lsu_valid;
   assign orphan_error = orphan_q;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_vld_d = lock_vld_q;
      lock_idx_d = lock_idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      orphan_d   = orphan_q;
      fifo_d     = fifo_q;
      if (clear) begin
         rr_ptr_d   = '0;
         lock_vld_d = 1'b0;
         lock_idx_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         orphan_d   = 1'b0;
      end else if (active) begin
         if (hs) begin
            rr_ptr_d = (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
         end
         lock_vld_d = lsu_valid & ~lsu_ready;
         lock_idx_d = win;
         if (push) begin
            fifo_d[wr_ptr_q[PW-1:0]] = win;
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (lsu_rvalid && empty) begin
            orphan_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         rr_ptr_q   <= '0;
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         orphan_q   <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_vld_q <= lock_vld_d;
         lock_idx_q <= lock_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         orphan_q   <= orphan_d;
      end
   end

   // Entry contents are only meaningful between the pointers, so no reset needed.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_dca_matrix_lsu_arbiter.sv
module tb_dca_matrix_lsu_arbiter;

   localparam int NR   = 3;
   localparam int BWI  = 32;
   localparam int BWD  = 32;
   localparam int MAXO = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstnn;
   logic            clear;
   logic            enable;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*BWI-1:0] req_inst;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [BWI-1:0]  lsu_inst;
   logic            lsu_rvalid;
   logic            lsu_rready;
   logic [BWD-1:0]  lsu_rdata;
   logic [NR-1:0]   rsp_valid;
   logic [NR-1:0]   rsp_ready;
   logic [BWD-1:0]  rsp_data;
   logic [2:0]      outstanding;
   logic            busy;
   logic            orphan_error;

   dca_matrix_lsu_arbiter #(
      .NUM_REQ(NR), .BW_LSU_INST(BWI), .BW_RDATA(BWD), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
      .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_inst(lsu_inst),
      .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .outstanding(outstanding), .busy(busy), .orphan_error(orphan_error)
   );

   // ---------------- reference model ----------------
   // Order queue of channels whose reads are in flight (the scoreboard).
   logic [1:0] exp_q[$];
   int         m_rr;       // channel that gets first look next
   int         m_hold;     // channel offered but not accepted last cycle, -1 if none
   bit         m_orphan;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic bit is_rd(input int ch);
      logic [BWI-1:0] w;
      w = req_inst[ch*BWI +: BWI];
      return (w[1:0] == 2'b01);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_rr     = 0;
      m_hold   = -1;
      m_orphan = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_inst(input int ch, input logic [1:0] opc);
      logic [BWI-1:0] r;
      r = $urandom();
      r[1:0] = opc;
      req_inst[ch*BWI +: BWI] = r;
   endtask

   // One clock: compare every output against the model for the current inputs,
   // then advance the model on the clock edge.
   task automatic step();
      bit          act;
      bit          full;
      bit [NR-1:0] elig;
      int          win;
      int          c;
      int          h;
      bit          vld;
      logic [2:0]  e_rdy;
      logic [2:0]  e_rsp;
      bit          e_rr;
      #1;
      if (!rstnn) model_reset();
      act  = rstnn && enable;
      full = (exp_q.size() == MAXO);
      for (int i = 0; i < NR; i++)
         elig[i] = act && req_valid[i] && !(is_rd(i) && full);
      win = -1;
      if (m_hold >= 0 && elig[m_hold]) win = m_hold;
      else begin
         for (int k = 0; k < NR; k++) begin
            c = (m_rr + k) % NR;
            if (win < 0 && elig[c]) win = c;
         end
      end
      vld   = (win >= 0);
      e_rdy = (vld && lsu_ready) ? 3'(1 << win) : 3'b000;
      if (exp_q.size() == 0) begin
         e_rsp = 3'b000;
         e_rr  = act;
      end else begin
         h     = int'(exp_q[0]);
         e_rsp = (act && lsu_rvalid) ? 3'(1 << h) : 3'b000;
         e_rr  = act && rsp_ready[h];
      end
      chk("lsu_valid", 32'(lsu_valid), 32'(vld));
      if (vld) chk("lsu_inst", lsu_inst, req_inst[win*BWI +: BWI]);
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("lsu_rready", 32'(lsu_rready), 32'(e_rr));
      chk("rsp_data", rsp_data, lsu_rdata);
      chk("outstanding", 32'(outstanding), 32'(exp_q.size()));
      chk("busy", 32'(busy), 32'((exp_q.size() != 0) || vld));
      chk("orphan_error", 32'(orphan_error), 32'(m_orphan));
      @(posedge clk);
      if (!rstnn || clear) model_reset();
      else if (enable) begin
         if (lsu_rvalid && exp_q.size() == 0) m_orphan = 1'b1;
         if (exp_q.size() != 0 && lsu_rvalid && rsp_ready[exp_q[0]]) void'(exp_q.pop_front());
         if (vld && lsu_ready) begin
            m_rr = (win + 1) % NR;
            if (is_rd(win)) exp_q.push_back(2'(win));
         end
         m_hold = (vld && !lsu_ready) ? win : -1;
      end
      #1;
   endtask

   // ---------------- directed + random sequence ----------------
   logic [2:0]     t2_seq [4];
   logic [BWD-1:0] dval;
   logic [BWI-1:0] inst1;

   initial begin
      t2_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
      model_reset();
      rstnn = 1'b0; clear = 1'b0; enable = 1'b1;
      req_valid = 3'b111; lsu_ready = 1'b1; lsu_rvalid = 1'b0;
      rsp_ready = 3'b000; lsu_rdata = '0; req_inst = '0;
      for (int i = 0; i < NR; i++) set_inst(i, 2'b01);

      // Reset: every valid/ready output low even with requests pending.
      step(); step();
      chk("rst_lsu_valid", 32'(lsu_valid), 32'd0);
      chk("rst_lsu_rready", 32'(lsu_rready), 32'd0);

      // 1: all three reads valid, LSU always ready; fills the FIFO then stalls.
      rstnn = 1'b1;
      #1;
      chk("t1_first_grant", 32'(req_ready), 32'h1);
      for (int i = 0; i < 6; i++) step();
      chk("t1_outstanding_full", 32'(outstanding), 32'd4);
      chk("t1_stalled", 32'(lsu_valid), 32'd0);

      // 2: return four beats; routed to ch0, ch1, ch2, ch0.
      req_valid = 3'b000; lsu_rvalid = 1'b1; rsp_ready = 3'b111;
      for (int k = 0; k < 4; k++) begin
         dval = $urandom(); lsu_rdata = dval;
         #1;
         chk("t2_rsp_valid", 32'(rsp_valid), 32'(t2_seq[k]));
         chk("t2_rsp_data", rsp_data, dval);
         step();
      end
      lsu_rvalid = 1'b0;
      chk("t2_drained", 32'(outstanding), 32'd0);

      // Bring the pointer back to ch0 with a ch2 write.
      set_inst(2, 2'b10); req_valid = 3'b100; step();

      // 3: ch1 held by a stalled LSU; ch0 appears mid-stall and must wait.
      set_inst(1, 2'b01); set_inst(0, 2'b01);
      inst1 = req_inst[1*BWI +: BWI];
      req_valid = 3'b010; lsu_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) req_valid = 3'b011;
         step();
         chk("t3_hold_inst", lsu_inst, inst1);
      end
      lsu_ready = 1'b1;
      step();
      req_valid = 3'b001;
      #1;
      chk("t3_ch0_next", 32'(req_ready), 32'h1);
      step();

      // 4: FIFO full; ch2 write passes, ch0 read waits for a pop.
      step(); step();
      chk("t4_full", 32'(outstanding), 32'd4);
      set_inst(2, 2'b10); req_valid = 3'b101;
      #1;
      chk("t4_write_granted", 32'(req_ready), 32'h4);
      step();
      chk("t4_write_untracked", 32'(outstanding), 32'd4);
      req_valid = 3'b001;
      step();
      lsu_rvalid = 1'b1; rsp_ready = 3'b111; lsu_rdata = $urandom();
      step();
      lsu_rvalid = 1'b0;
      #1;
      chk("t4_read_after_pop", 32'(req_ready), 32'h1);
      step();
      req_valid = 3'b000; lsu_rvalid = 1'b1;
      for (int k = 0; k < 8; k++) if (exp_q.size() != 0) begin
         lsu_rdata = $urandom(); step();
      end
      chk("t4_drained", 32'(outstanding), 32'd0);

      // 5: orphan beat with nothing outstanding.
      rsp_ready = 3'b000;
      #1;
      chk("t5_drain_ready", 32'(lsu_rready), 32'd1);
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
      step(); step();
      lsu_rvalid = 1'b0;
      step(); step();
      chk("t5_orphan_sticky", 32'(orphan_error), 32'd1);
      clear = 1'b1; step(); clear = 1'b0;
      chk("t5_orphan_cleared", 32'(orphan_error), 32'd0);

      // 6: clear with three outstanding, then reset mid-handshake.
      set_inst(0, 2'b01); req_valid = 3'b001; lsu_ready = 1'b1;
      step(); step(); step();
      chk("t6_three", 32'(outstanding), 32'd3);
      req_valid = 3'b000; clear = 1'b1; step(); clear = 1'b0;
      chk("t6_cleared", 32'(outstanding), 32'd0);
      for (int i = 0; i < NR; i++) set_inst(i, 2'b01);
      req_valid = 3'b111;
      #1;
      chk("t6_ptr_zero", 32'(req_ready), 32'h1);
      lsu_ready = 1'b0;
      step();
      rstnn = 1'b0; lsu_rvalid = 1'b1; rsp_ready = 3'b111;
      #1;
      chk("t6_rst_valid", 32'(lsu_valid), 32'd0);
      chk("t6_rst_ready", 32'(req_ready), 32'd0);
      chk("t6_rst_rsp", 32'(rsp_valid), 32'd0);
      chk("t6_rst_rready", 32'(lsu_rready), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      step(); step();
      rstnn = 1'b1; lsu_rvalid = 1'b0;

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         enable    = ($urandom_range(0, 9) != 0);
         clear     = ($urandom_range(0, 59) == 0);
         req_valid = 3'($urandom_range(0, 7));
         for (int i = 0; i < NR; i++)
            set_inst(i, ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3)));
         lsu_ready  = ($urandom_range(0, 3) != 0);
         lsu_rvalid = ($urandom_range(0, 2) == 0);
         rsp_ready  = 3'($urandom_range(0, 7));
         lsu_rdata  = $urandom();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
